rx_serial_7o1: RTL and testbench
================================

Name: rx_serial_7O1

Overview:
- Asynchronous serial receiver for the 7O1 frame produced by tx_serial_7O1: 1 start bit, 7 data bits LSB first, odd parity, 1 stop bit.
- Sits directly downstream of the transmitter. Recovers each character from the serial line and presents it to the consuming logic with status flags.
- Samples the line at mid-bit using a clock-count bit timer.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); minimum 8.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low; 0 forces the reset state.
dado_serial  in  1  serial line; idle level is 1.
limpa  in  1  clears tem_dado; 1-cycle pulse or level.
dados_ascii  out  7  last received character.
paridade_ok  out  1  1 when the last character's odd parity checked correctly.
erro_stop  out  1  1 when the last character's stop bit was sampled as 0.
pronto  out  1  1-cycle pulse when a frame completes.
tem_dado  out  1  set with pronto; held until limpa.
db_estado  out  4  current FSM state code.
db_dado_serial  out  1  synchronized serial line.

Behaviour:
- Line input: dado_serial passes through a 2-FF synchronizer; both FFs reset to 1. All logic uses the synchronized line (sl). db_dado_serial = sl.
- Reset values (reset=0): state INICIAL; dados_ascii=0; paridade_ok=0; erro_stop=0; pronto=0; tem_dado=0; bit timer, bit counter and shift register cleared.
- FSM states and db_estado codes:
  - INICIAL (0): go to ESPERA next cycle.
  - ESPERA (1): wait for a falling edge of sl (sl_prev=1, sl=0) → START. A line held low (break) does not start a frame.
  - START (2): count CLKS_PER_BIT/2 cycles, then sample. sl=0 → DADOS with timer cleared. sl=1 → ESPERA (glitch rejected, no pronto).
  - DADOS (3): every CLKS_PER_BIT cycles sample sl into shift register bit[count], LSB first. After 7 samples → PARIDADE.
  - PARIDADE (4): after CLKS_PER_BIT cycles sample the parity bit p.
  - STOP (5): after CLKS_PER_BIT cycles sample the stop bit → FIM.
  - FIM (6): one cycle, then → ESPERA.
- Actions in FIM:
  - dados_ascii ← shift register.
  - paridade_ok ← XOR of the 7 data bits and p equals 1 (odd parity).
  - erro_stop ← NOT stop sample.
  - pronto=1 for this cycle only; tem_dado ← 1.
- Outputs hold between frames. A frame with a parity or stop error still updates outputs and pulses pronto.
- Latency: pronto asserts 9.5×CLKS_PER_BIT + 2..4 cycles after the input falling edge.
- limpa: tem_dado ← 0 next cycle. If limpa coincides with FIM, the set wins and tem_dado stays 1.
- Overrun: a new frame while tem_dado=1 overwrites dados_ascii and flags; tem_dado stays 1.
- Stop bit sampled 0: erro_stop=1. FSM returns to ESPERA and needs a fresh falling edge, so a line held low does not retrigger.
- Reset mid-frame: immediate return to reset state. The partial frame is discarded; no pronto.
- Timer width: clog2(CLKS_PER_BIT). Counter wrap is never relied upon; the timer clears on each sample.

Test Plan:
- Bench uses CLKS_PER_BIT=16; all frames start from idle line=1.
- Reset: reset=0 for 20 cycles, line=1 → all outputs 0, db_estado=1 after release, no pronto for 50 cycles.
- Frames for 7'h35, 7'h55, 7'h7E (parity bit 1 each) and 7'h7F (parity bit 0), stop bit 1 → for each, exactly one pronto pulse. dados_ascii equals the sent character, paridade_ok=1, erro_stop=0, tem_dado=1. pronto occurs 154±2 cycles after the start edge.
- 7'h35 sent with parity bit 0 → pronto pulses, dados_ascii=7'h35, paridade_ok=0.
- 7'h55 sent with stop bit 0, line then held 0 for 200 cycles → erro_stop=1, a single pronto, no second frame until the line returns to 1 and falls again.
- 4-cycle low glitch on idle line → state returns to ESPERA, no pronto. Then limpa pulse → tem_dado=0. Then limpa asserted in the FIM cycle of a 7'h7E frame → tem_dado=1.
- reset=0 for 1 cycle during data bit 3 of 7'h7F → outputs cleared, no pronto for that frame. A following 7'h55 frame is received correctly.

Source files
------------

// File: rtl/rx_serial_7o1.sv
`timescale 1ns/1ps
// Serial receiver for 7O1 frames: start bit, 7 data bits LSB first, odd parity, stop bit.
// Mid-bit sampling with a clock-count bit timer; results are presented one cycle after the frame ends.
module rx_serial_7o1 #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dado_serial,
    input  logic       limpa,
    output logic [6:0] dados_ascii,
    output logic       paridade_ok,
    output logic       erro_stop,
    output logic       pronto,
    output logic       tem_dado,
    output logic [3:0] db_estado,
    output logic       db_dado_serial
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        ESPERA   = 4'd1,
        START    = 4'd2,
        DADOS    = 4'd3,
        PARIDADE = 4'd4,
        STOP     = 4'd5,
        FIM      = 4'd6
    } state_t;

    state_t          state, state_n;
    logic            sync1, sl, sl_prev;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_cnt;
    logic [6:0]      shift;
    logic            par_s, stop_s;
    logic            tick_half, tick_bit, timer_run, timer_clr;

    // Two-flop synchronizer plus previous-sample register for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b1;
            sl      <= 1'b1;
            sl_prev <= 1'b1;
        end else begin
            sync1   <= dado_serial;
            sl      <= sync1;
            sl_prev <= sl;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= INICIAL;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        tick_half = (timer == HALF_LAST);
        tick_bit  = (timer == BIT_LAST);
        timer_run = 1'b0;
        case (state)
            INICIAL: state_n = ESPERA;
            ESPERA: begin
                if (sl_prev && !sl) state_n = START;
            end
            START: begin
                timer_run = 1'b1;
                if (tick_half) state_n = sl ? ESPERA : DADOS;
            end
            DADOS: begin
                timer_run = 1'b1;
                if (tick_bit && bit_cnt == 3'd6) state_n = PARIDADE;
            end
            PARIDADE: begin
                timer_run = 1'b1;
                if (tick_bit) state_n = STOP;
            end
            STOP: begin
                timer_run = 1'b1;
                if (tick_bit) state_n = FIM;
            end
            FIM:     state_n = ESPERA;
            default: state_n = INICIAL;
        endcase
        // Timer restarts on every state change and after every data sample
        timer_clr = !timer_run || (state_n != state) || (state == DADOS && tick_bit);
    end

    // Bit timer, sample capture and result registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer       <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            par_s       <= 1'b0;
            stop_s      <= 1'b0;
            dados_ascii <= '0;
            paridade_ok <= 1'b0;
            erro_stop   <= 1'b0;
            pronto      <= 1'b0;
            tem_dado    <= 1'b0;
        end else begin
            timer  <= timer_clr ? '0 : timer + TW'(1);
            pronto <= 1'b0;

            if (state != DADOS) begin
                bit_cnt <= '0;
            end else if (tick_bit) begin
                shift[bit_cnt] <= sl;
                bit_cnt        <= bit_cnt + 3'd1;
            end

            if (state == PARIDADE && tick_bit) par_s  <= sl;
            if (state == STOP && tick_bit)     stop_s <= sl;

            // Frame completion takes priority over a coincident clear request
            if (state == FIM) begin
                dados_ascii <= shift;
                paridade_ok <= ^{shift, par_s};
                erro_stop   <= ~stop_s;
                pronto      <= 1'b1;
                tem_dado    <= 1'b1;
            end else if (limpa) begin
                tem_dado <= 1'b0;
            end
        end
    end

    assign db_estado      = state;
    assign db_dado_serial = sl;

endmodule

// File: tb/tb_rx_serial_7o1.sv
`timescale 1ns/1ps
// Directed, table-driven bench for rx_serial_7o1 with CLKS_PER_BIT=16.
module tb_rx_serial_7o1;

    localparam int unsigned N = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       dado_serial = 1'b1;
    logic       limpa = 1'b0;
    logic [6:0] dados_ascii;
    logic       paridade_ok, erro_stop, pronto, tem_dado;
    logic [3:0] db_estado;
    logic       db_dado_serial;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pronto_cnt = 0;
    int pronto_cyc = 0;
    int start_cyc = 0;

    typedef struct {
        logic [6:0] data;
        logic       par;
        logic       stop;
        logic [6:0] exp_data;
        logic       exp_pok;
        logic       exp_estop;
    } vec_t;

    vec_t vecs[5];

    rx_serial_7o1 #(.CLKS_PER_BIT(N)) dut (
        .clock          (clock),
        .reset          (reset),
        .dado_serial    (dado_serial),
        .limpa          (limpa),
        .dados_ascii    (dados_ascii),
        .paridade_ok    (paridade_ok),
        .erro_stop      (erro_stop),
        .pronto         (pronto),
        .tem_dado       (tem_dado),
        .db_estado      (db_estado),
        .db_dado_serial (db_dado_serial)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (pronto) begin
            pronto_cnt <= pronto_cnt + 1;
            pronto_cyc <= cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_latency(input string name);
        int lat;
        lat = pronto_cyc - start_cyc;
        checks++;
        if (lat < 152 || lat > 156) begin
            errors++;
            $display("FAIL %s: latency %0d expected 152..156", name, lat);
        end
    endtask

    task automatic drive_bit(input logic b);
        dado_serial = b;
        repeat (N) @(negedge clock);
    endtask

    // Sends a full frame starting at a negedge; line is left at the stop-bit level
    task automatic send_frame(input logic [6:0] d, input logic p, input logic s);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    initial begin
        int p0;
        bit found;

        vecs[0] = '{7'h35, 1'b1, 1'b1, 7'h35, 1'b1, 1'b0};
        vecs[1] = '{7'h55, 1'b1, 1'b1, 7'h55, 1'b1, 1'b0};
        vecs[2] = '{7'h7E, 1'b1, 1'b1, 7'h7E, 1'b1, 1'b0};
        vecs[3] = '{7'h7F, 1'b0, 1'b1, 7'h7F, 1'b1, 1'b0};
        vecs[4] = '{7'h35, 1'b0, 1'b1, 7'h35, 1'b0, 1'b0};

        // Reset state
        repeat (20) @(negedge clock);
        chk("rst_dados",    32'(dados_ascii), 32'h0);
        chk("rst_pok",      32'(paridade_ok), 32'h0);
        chk("rst_estop",    32'(erro_stop),   32'h0);
        chk("rst_pronto",   32'(pronto),      32'h0);
        chk("rst_tem_dado", 32'(tem_dado),    32'h0);
        chk("rst_estado",   32'(db_estado),   32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("post_rst_estado", 32'(db_estado), 32'h1);
        repeat (50) @(negedge clock);
        chk("post_rst_no_pronto", 32'(pronto_cnt), 32'h0);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            p0 = pronto_cnt;
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
            repeat (4) @(negedge clock);
            chk($sformatf("v%0d_pronto_cnt", v), 32'(pronto_cnt - p0), 32'h1);
            chk($sformatf("v%0d_dados", v),    32'(dados_ascii), 32'(vecs[v].exp_data));
            chk($sformatf("v%0d_pok", v),      32'(paridade_ok), 32'(vecs[v].exp_pok));
            chk($sformatf("v%0d_estop", v),    32'(erro_stop),   32'(vecs[v].exp_estop));
            chk($sformatf("v%0d_tem_dado", v), 32'(tem_dado),    32'h1);
            chk_latency($sformatf("v%0d_latency", v));
        end

        // Stop bit 0, line then held low
        p0 = pronto_cnt;
        send_frame(7'h55, 1'b1, 1'b0);
        repeat (200) @(negedge clock);
        chk("brk_pronto_cnt", 32'(pronto_cnt - p0), 32'h1);
        chk("brk_estop",      32'(erro_stop),       32'h1);
        chk("brk_dados",      32'(dados_ascii),     32'h55);
        chk("brk_estado",     32'(db_estado),       32'h1);
        dado_serial = 1'b1;
        repeat (20) @(negedge clock);
        chk("brk_no_retrigger", 32'(pronto_cnt - p0), 32'h1);

        // Short low glitch on idle line
        p0 = pronto_cnt;
        dado_serial = 1'b0;
        repeat (4) @(negedge clock);
        dado_serial = 1'b1;
        repeat (30) @(negedge clock);
        chk("glitch_no_pronto", 32'(pronto_cnt - p0), 32'h0);
        chk("glitch_estado",    32'(db_estado),       32'h1);

        // limpa clears tem_dado
        limpa = 1'b1;
        @(negedge clock);
        limpa = 1'b0;
        chk("limpa_clear", 32'(tem_dado), 32'h0);

        // limpa coinciding with FIM: set wins
        found = 1'b0;
        p0 = pronto_cnt;
        fork
            send_frame(7'h7E, 1'b1, 1'b1);
            begin
                for (int i = 0; i < 300; i++) begin
                    @(negedge clock);
                    if (db_estado == 4'd6) begin
                        limpa = 1'b1;
                        @(negedge clock);
                        limpa = 1'b0;
                        found = 1'b1;
                        break;
                    end
                end
            end
        join
        repeat (4) @(negedge clock);
        chk("fim_seen",         32'(found),            32'h1);
        chk("fim_limpa_tem",    32'(tem_dado),         32'h1);
        chk("fim_limpa_pronto", 32'(pronto_cnt - p0),  32'h1);
        chk("fim_limpa_dados",  32'(dados_ascii),      32'h7E);

        // Reset pulse during data bit 3 of 7'h7F, then transmission abandoned
        p0 = pronto_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        dado_serial = 1'b1;
        repeat (8) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_dados",  32'(dados_ascii), 32'h0);
        chk("midrst_tem",    32'(tem_dado),    32'h0);
        chk("midrst_pok",    32'(paridade_ok), 32'h0);
        chk("midrst_estado", 32'(db_estado),   32'h0);
        reset = 1'b1;
        repeat (200) @(negedge clock);
        chk("midrst_no_pronto", 32'(pronto_cnt - p0), 32'h0);

        // Following frame is received correctly
        p0 = pronto_cnt;
        send_frame(7'h55, 1'b1, 1'b1);
        repeat (4) @(negedge clock);
        chk("after_rst_pronto", 32'(pronto_cnt - p0), 32'h1);
        chk("after_rst_dados",  32'(dados_ascii),     32'h55);
        chk("after_rst_pok",    32'(paridade_ok),     32'h1);
        chk("after_rst_estop",  32'(erro_stop),       32'h0);
        chk("after_rst_tem",    32'(tem_dado),        32'h1);
        chk_latency("after_rst_latency");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
